// File: rtl/ppt_ctrl_pkg.sv
// Shared types and constants for the presentation-controller key debouncer.
package ppt_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConfirmPress,
        StPressed,
        StConfirmRelease
    } key_state_e;

    localparam int unsigned KEY_NEXT = 0;
    localparam int unsigned KEY_PREV = 1;
    localparam int unsigned NUM_KEYS = 2;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/debounce_channel.sv
// One key's debounce FSM; auto-repeat added when KEY_DEBOUNCER_AUTOREPEAT_EN is defined.
module debounce_channel
    import ppt_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SAMPLES = 4,
    parameter int unsigned REPEAT_DELAY     = 32,
    parameter int unsigned REPEAT_PERIOD    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic key_level,
    output logic press_pulse,
    output logic btn_state
);

    localparam logic [CNT_W-1:0] DsCnt = CNT_W'(DEBOUNCE_SAMPLES);

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             accept;
    logic             pulse_q, pulse_d;

    assign cnt_inc = (cnt_q >= DsCnt) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (sample_en) begin
            unique case (state_q)
                StIdle: begin
                    if (key_level) begin
                        if (DEBOUNCE_SAMPLES == 1) begin
                            state_d = StPressed;
                            cnt_d   = '0;
                            accept  = 1'b1;
                        end else begin
                            state_d = StConfirmPress;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                StConfirmPress: begin
                    if (!key_level) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_inc == DsCnt) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                        accept  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StPressed: begin
                    if (!key_level) begin
                        if (DEBOUNCE_SAMPLES == 1) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            state_d = StConfirmRelease;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                StConfirmRelease: begin
                    if (key_level) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else if (cnt_inc == DsCnt) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam logic [HOLD_W-1:0] DelayCnt  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] PeriodCnt = HOLD_W'(REPEAT_PERIOD);

    // hold_q counts toward the first delay, then reloads for each repeat period
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic              rep_q, rep_d;
    logic              repeat_hit;

    assign hold_inc = hold_q + HOLD_W'(1);

    always_comb begin
        hold_d     = hold_q;
        rep_d      = rep_q;
        repeat_hit = 1'b0;
        if (accept) begin
            hold_d = '0;
            rep_d  = 1'b0;
        end else if (sample_en && (state_q == StPressed) && key_level) begin
            if (hold_inc == (rep_q ? PeriodCnt : DelayCnt)) begin
                repeat_hit = 1'b1;
                hold_d     = '0;
                rep_d      = 1'b1;
            end else begin
                hold_d = hold_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

    assign pulse_d = accept | repeat_hit;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{HOLD_W'(REPEAT_DELAY), HOLD_W'(REPEAT_PERIOD)};

    assign pulse_d = accept;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign press_pulse = pulse_q;
    assign btn_state   = (state_q == StPressed) || (state_q == StConfirmRelease);

endmodule

// File: rtl/key_debouncer.sv
// Two-key debouncer: shared tick synchronizer/edge detect feeding two debounce channels.
// Optional auto-repeat enabled by defining KEY_DEBOUNCER_AUTOREPEAT_EN.
module key_debouncer
    import ppt_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SAMPLES = 4,
    parameter int unsigned REPEAT_DELAY     = 32,
    parameter int unsigned REPEAT_PERIOD    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_in,
    input  logic [NUM_KEYS-1:0] btn_in,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] btn_state
);

    logic [1:0]          tick_sync_q;
    logic                tick_prev_q;
    logic [NUM_KEYS-1:0] btn_sync1_q, btn_sync2_q;
    logic                sample_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_sync_q <= '0;
            tick_prev_q <= 1'b0;
            btn_sync1_q <= '0;
            btn_sync2_q <= '0;
        end else begin
            tick_sync_q <= {tick_sync_q[0], tick_in};
            tick_prev_q <= tick_sync_q[1];
            btn_sync1_q <= btn_in;
            btn_sync2_q <= btn_sync1_q;
        end
    end

    assign sample_en = tick_sync_q[1] & ~tick_prev_q;

    debounce_channel #(
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan_next (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .key_level  (btn_sync2_q[KEY_NEXT]),
        .press_pulse(press_pulse[KEY_NEXT]),
        .btn_state  (btn_state[KEY_NEXT])
    );

    debounce_channel #(
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan_prev (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .key_level  (btn_sync2_q[KEY_PREV]),
        .press_pulse(press_pulse[KEY_PREV]),
        .btn_state  (btn_state[KEY_PREV])
    );

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: reference model predicts pulses, a monitor checks them.
module tb_key_debouncer;

    localparam int DS = 4;
    localparam int RD = 32;
    localparam int RP = 8;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic [1:0] btn_in = 2'b00;
    logic [1:0] press_pulse;
    logic [1:0] btn_state;

    always #5 clk = ~clk;

    key_debouncer #(
        .DEBOUNCE_SAMPLES(DS),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .btn_in     (btn_in),
        .press_pulse(press_pulse),
        .btn_state  (btn_state)
    );

    typedef struct {
        int         tick;
        logic [1:0] bits;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   tick_num = 0;
    int   pulse_cnt[2] = '{0, 0};

    // Reference model: level flips after DS consecutive samples that disagree with it.
    logic [1:0] m_level;
    int         m_run[2];
    int         m_hold[2];

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got=%0d required=%0d (t=%0t)", name, got, req, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 2'b00;
        for (int k = 0; k < 2; k++) begin
            m_run[k]  = 0;
            m_hold[k] = 0;
        end
    endtask

    task automatic model_step(input logic [1:0] v, output logic [1:0] pulse);
        pulse = 2'b00;
        for (int k = 0; k < 2; k++) begin
            bit settled;
            settled = (m_run[k] == 0);
            if (v[k] != m_level[k]) begin
                m_run[k]++;
                if (m_run[k] == DS) begin
                    m_level[k] = v[k];
                    m_run[k]   = 0;
                    if (v[k]) begin
                        pulse[k]  = 1'b1;
                        m_hold[k] = 0;
                    end
                end
            end else begin
                if (AUTO && m_level[k] && settled) begin
                    m_hold[k]++;
                    if (m_hold[k] == RD || (m_hold[k] > RD && (m_hold[k] - RD) % RP == 0))
                        pulse[k] = 1'b1;
                end
                m_run[k] = 0;
            end
        end
    endtask

    task automatic do_tick(input logic [1:0] v);
        logic [1:0] p;
        @(negedge clk);
        btn_in = v;
        model_step(v, p);
        if (p != 2'b00) exp_q.push_back('{tick: tick_num + 1, bits: p});
        repeat (4) @(negedge clk);
        tick_num++;
        tick_in = 1'b1;
        repeat (5) @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        check_val("btn_state", int'(btn_state), int'(m_level));
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (press_pulse != 2'b00) begin
                for (int k = 0; k < 2; k++) pulse_cnt[k] += int'(press_pulse[k]);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: got=%b at tick %0d required=none",
                             press_pulse, tick_num);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.tick != tick_num || e.bits != press_pulse) begin
                        failures++;
                        $display("FAIL pulse: got=%b at tick %0d required=%b at tick %0d",
                                 press_pulse, tick_num, e.bits, e.tick);
                    end
                end
            end
        end
    endtask

    task automatic release_all();
        repeat (DS + 1) do_tick(2'b00);
    endtask

    initial begin
        int         c0;
        logic [1:0] cur;
        logic [1:0] s0;

        model_reset();
        fork
            monitor_loop();
        join_none

        #12;
        check_val("reset_pulse", int'(press_pulse), 0);
        check_val("reset_state", int'(btn_state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Steady press: one pulse on the DS-th sample
        c0 = pulse_cnt[0];
        repeat (DS - 1) do_tick(2'b01);
        check_val("no_pulse_before_ds", pulse_cnt[0] - c0, 0);
        repeat (6 - (DS - 1)) do_tick(2'b01);
        check_val("steady_press_pulses", pulse_cnt[0] - c0, 1);
        check_val("steady_press_state", int'(btn_state[0]), 1);
        release_all();
        check_val("released_state", int'(btn_state), 0);

        // Bounce pattern 1,1,0,1,1,1,1
        c0 = pulse_cnt[0];
        do_tick(2'b01); do_tick(2'b01); do_tick(2'b00);
        do_tick(2'b01); do_tick(2'b01); do_tick(2'b01);
        check_val("bounce_early", pulse_cnt[0] - c0, 0);
        do_tick(2'b01);
        check_val("bounce_pulse", pulse_cnt[0] - c0, 1);
        release_all();

        // Both keys together
        c0 = pulse_cnt[0] + pulse_cnt[1];
        repeat (DS + 1) do_tick(2'b11);
        check_val("both_keys_pulses", pulse_cnt[0] + pulse_cnt[1] - c0, 2);
        check_val("both_keys_state", int'(btn_state), 3);
        release_all();

        // Long hold: auto-repeat count
        c0 = pulse_cnt[1];
        repeat (60) do_tick(2'b10);
        check_val("hold60_pulses", pulse_cnt[1] - c0, AUTO ? 5 : 1);
        release_all();

        // Reset while pressed clears state with no clock edge
        repeat (DS) do_tick(2'b01);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_reset_state", int'(btn_state), 0);
        check_val("async_reset_pulse", int'(press_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        btn_in = 2'b00;
        release_all();

        // Reset in CONFIRM_PRESS with count 3; held key re-debounced afterwards
        c0 = pulse_cnt[0];
        repeat (3) do_tick(2'b01);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("reset_cp_state", int'(btn_state), 0);
        check_val("reset_cp_pulse", int'(press_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (DS - 1) do_tick(2'b01);
        check_val("reset_cp_no_early", pulse_cnt[0] - c0, 0);
        do_tick(2'b01);
        check_val("reset_cp_pulse_after", pulse_cnt[0] - c0, 1);
        release_all();

        // tick_in stuck low: no sampling
        c0 = pulse_cnt[0] + pulse_cnt[1];
        s0 = btn_state;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            btn_in = 2'($urandom_range(0, 3));
            repeat (3) @(negedge clk);
        end
        btn_in = 2'b00;
        repeat (4) @(negedge clk);
        check_val("stuck_tick_pulses", pulse_cnt[0] + pulse_cnt[1] - c0, 0);
        check_val("stuck_tick_state", int'(btn_state), int'(s0));

        // Randomized bouncing on both keys
        cur = 2'b00;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 2; k++)
                if ($urandom_range(0, 3) == 0) cur[k] = ~cur[k];
            do_tick(cur);
        end
        release_all();

        repeat (5) @(negedge clk);
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
